// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with open-drain pad enables.
// The host holds the clock low to inhibit the device, then pulls data low to request a send.
// It shifts out 8 data bits (LSB first), odd parity and the stop bit on the device clock,
// and finally samples the device ACK/NACK.
// Optional macro PS2_TX_TIMEOUT_EN adds a per-edge watchdog that aborts a stalled transfer
// with an err pulse.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             clk_meta;
    logic             clk_sync;
    logic             data_meta;
    logic             data_sync;
    logic             armed;
    logic [1:0]       low_cnt;
    logic             fall;
    logic [9:0]       frame;
    logic             data_drv;
    logic [3:0]       edge_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic             nack;
    logic             timeout;

    // Double-flop both pads into the clk domain; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    // A falling edge counts only after a high level followed by 4 consecutive low samples.
    assign fall = armed && !clk_sync && (low_cnt == 2'd3);

    // Track the low run length and re-arm whenever the synchronized clock is seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed   <= 1'b0;
            low_cnt <= 2'd0;
        end else if (clk_sync) begin
            armed   <= 1'b1;
            low_cnt <= 2'd0;
        end else if (armed) begin
            if (low_cnt == 2'd3) begin
                armed   <= 1'b0;
                low_cnt <= 2'd0;
            end else begin
                low_cnt <= low_cnt + 2'd1;
            end
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_active;

    assign wd_active = (state == REQUEST) || (state == SHIFT) ||
                       (state == ACK) || (state == WAIT_IDLE);
    assign timeout   = wd_active && (wd_cnt == WD_LIMIT);

    // Watchdog restarts on every state change and every valid device clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (!wd_active || (state_n != state) || fall) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and pad/handshake outputs decoded from the current state.
    always_comb begin
        state_n     = state;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid) state_n = INHIBIT;
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt == INH_LAST) state_n = REQUEST;
            end
            REQUEST: begin
                ps2_data_oe = 1'b1;
                if (fall) state_n = SHIFT;
            end
            SHIFT: begin
                ps2_data_oe = data_drv;
                if (fall && (edge_cnt == 4'd9)) state_n = ACK;
            end
            ACK: begin
                if (fall) state_n = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done    = ~nack;
                    err     = nack;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            state_n     = IDLE;
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
            done        = 1'b0;
            err         = 1'b1;
        end
    end

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Frame shifter: latch {stop, parity, data} on accept and present one bit per device edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame    <= '0;
            data_drv <= 1'b0;
            edge_cnt <= 4'd0;
            inh_cnt  <= '0;
            nack     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        frame   <= {1'b1, ~^tx_data, tx_data};
                        inh_cnt <= '0;
                    end
                end
                INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                end
                REQUEST, SHIFT: begin
                    if (fall && !timeout) begin
                        data_drv <= ~frame[0];
                        frame    <= {1'b1, frame[9:1]};
                        edge_cnt <= (state == REQUEST) ? 4'd1 : edge_cnt + 4'd1;
                    end
                end
                ACK: begin
                    if (fall) nack <= data_sync;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench for ps2_host_tx with an open-drain PS/2 device model.
// Define PS2_TX_TIMEOUT_EN for both files to exercise the watchdog variant.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 5000;
    localparam int HALF = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic glitch   = 1'b0;

    wire pad_clk  = dev_clk & ~glitch & ~ps2_clk_oe;
    wire pad_data = dev_data & ~ps2_data_oe;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int acc_cnt  = 0;
    int inh_run  = 0;
    int last_inh = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (pad_clk),
        .ps2_data_in(pad_data),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Event monitor sampled just after each falling edge of clk.
    always @(negedge clk) begin
        #1;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (tx_valid && tx_ready && !rst) acc_cnt++;
        if (ps2_clk_oe) begin
            inh_run++;
        end else if (inh_run != 0) begin
            last_inh = inh_run;
            inh_run  = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] expectedFrame(input logic [7:0] b);
        int   ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (int'(b) >> i) & 1;
        par = ((ones % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic checkFrame(input string tag, input logic [7:0] b, input logic [10:0] seen);
        logic [10:0] exp;
        exp = expectedFrame(b);
        checkOutput({tag, "_start"},  32'(seen[0]),   32'(exp[0]));
        checkOutput({tag, "_data"},   32'(seen[8:1]), 32'(exp[8:1]));
        checkOutput({tag, "_parity"}, 32'(seen[9]),   32'(exp[9]));
        checkOutput({tag, "_stop"},   32'(seen[10]),  32'(exp[10]));
    endtask

    task automatic sendByte(input logic [7:0] b, input bit hold, input logic [7:0] after_data);
        int n;
        n = 0;
        while (!tx_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_wait", 32'(tx_ready), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        checkOutput("ready_drop", 32'(tx_ready), 32'd0);
        tx_data = after_data;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic waitRequest(output bit found);
        int n;
        n     = 0;
        found = 1'b0;
        while (!found && n < 2000) begin
            @(negedge clk);
            n++;
            if (!ps2_clk_oe && ps2_data_oe) found = 1'b1;
        end
        checkOutput("request_seen", 32'(found), 32'd1);
    endtask

    // Device side: clocks 11 periods, samples host data at the end of each low phase.
    task automatic deviceFrame(input bit give_ack, input int glitch_bit, output logic [10:0] seen);
        bit found;
        seen = '1;
        waitRequest(found);
        if (found) begin
            repeat (50) @(negedge clk);
            seen[0] = pad_data;
            for (int i = 1; i <= 11; i++) begin
                dev_clk = 1'b0;
                repeat (HALF) @(negedge clk);
                if (i <= 10) seen[i] = pad_data;
                dev_clk = 1'b1;
                if (i == 10) dev_data = give_ack ? 1'b0 : 1'b1;
                if (i == glitch_bit) begin
                    repeat (HALF / 2) @(negedge clk);
                    glitch = 1'b1;
                    repeat (2) @(negedge clk);
                    glitch = 1'b0;
                    repeat (HALF / 2 - 2) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
            end
            dev_data = 1'b1;
        end
    endtask

    task automatic waitResult(input string tag, input int d0, input int e0,
                              input int exp_done, input int exp_err);
        int n;
        n = 0;
        while ((done_cnt + err_cnt) == (d0 + e0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        checkOutput({tag, "_done"}, 32'(done_cnt - d0), 32'(exp_done));
        checkOutput({tag, "_err"},  32'(err_cnt - e0),  32'(exp_err));
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] b, input bit give_ack,
                                 input int glitch_bit);
        int          d0;
        int          e0;
        logic [10:0] seen;
        d0 = done_cnt;
        e0 = err_cnt;
        sendByte(b, 1'b0, 8'($urandom));
        deviceFrame(give_ack, glitch_bit, seen);
        checkOutput({tag, "_inhibit_len"}, 32'(last_inh), 32'(INH));
        checkFrame(tag, b, seen);
        waitResult(tag, d0, e0, give_ack ? 1 : 0, give_ack ? 0 : 1);
        checkOutput({tag, "_ready"}, 32'(tx_ready), 32'd1);
    endtask

    initial begin
        #(950000);
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] bench time limit expired");
    end

    initial begin
        int          d0;
        int          e0;
        int          a0;
        int          n;
        bit          found;
        logic [7:0]  b;
        logic [10:0] seen;

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);

        $display("[TB] 0xED with ACK");
        applyStimulus("ed_ack", 8'hED, 1'b1, 0);

        $display("[TB] 0xF4 with NACK");
        applyStimulus("f4_nack", 8'hF4, 1'b0, 0);

        $display("[TB] tx_valid held during transfer");
        d0 = done_cnt;
        e0 = err_cnt;
        a0 = acc_cnt;
        sendByte(8'hED, 1'b1, 8'hAA);
        deviceFrame(1'b1, 0, seen);
        checkOutput("hold_single_accept", 32'(acc_cnt - a0), 32'd1);
        checkFrame("hold_first", 8'hED, seen);
        waitResult("hold_first", d0, e0, 1, 0);
        d0 = done_cnt;
        e0 = err_cnt;
        deviceFrame(1'b1, 0, seen);
        tx_valid = 1'b0;
        checkFrame("hold_second", 8'hAA, seen);
        waitResult("hold_second", d0, e0, 1, 0);
        checkOutput("hold_two_accepts", 32'(acc_cnt - a0), 32'd2);

        $display("[TB] clock glitch during shift");
        applyStimulus("glitch", 8'($urandom), 1'b1, 4);

        $display("[TB] random transfers");
        for (int k = 0; k < 3; k++) begin
            applyStimulus("random", 8'($urandom), 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] reset mid-transfer");
        b  = 8'($urandom) & 8'hEF;
        d0 = done_cnt;
        e0 = err_cnt;
        sendByte(b, 1'b0, 8'($urandom));
        waitRequest(found);
        repeat (50) @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i < 5) begin
                dev_clk = 1'b1;
                repeat (HALF) @(negedge clk);
            end
        end
        checkOutput("pre_reset_data_oe", 32'(ps2_data_oe), 32'(~((int'(b) >> 4) & 1) & 1));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("mid_rst_data_oe", 32'(ps2_data_oe), 32'd0);
        checkOutput("mid_rst_ready", 32'(tx_ready), 32'd1);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        rst     = 1'b0;
        dev_clk = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("mid_rst_no_err", 32'(err_cnt - e0), 32'd0);

        $display("[TB] silent device");
        d0 = done_cnt;
        e0 = err_cnt;
        sendByte(8'($urandom), 1'b0, 8'($urandom));
        waitRequest(found);
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        while (!err && n < TMO + 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycles", 32'(n), 32'(TMO));
        @(negedge clk);
        checkOutput("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
        checkOutput("timeout_ready", 32'(tx_ready), 32'd1);
        repeat (10) @(negedge clk);
        checkOutput("timeout_err", 32'(err_cnt - e0), 32'd1);
        checkOutput("timeout_no_done", 32'(done_cnt - d0), 32'd0);
`else
        n = 0;
        repeat (TMO + 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_busy", 32'(busy), 32'd1);
        checkOutput("stall_no_err", 32'(err_cnt - e0), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("stall_reset_ready", 32'(tx_ready), 32'd1);
`endif

        checkOutput("done_err_overlap", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 12000, the number of clk cycles the PS/2 clock is held low before the request (120 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1500000, the maximum clk cycles spent waiting on any single device clock edge (15 ms at 100 MHz).
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high when idle and able to accept a byte.
- ps2_clk_in  in  1  PS2Clk pad input, asynchronous.
- ps2_data_in  in  1  PS2Data pad input, asynchronous.
- ps2_clk_oe  out  1  1 drives the PS2Clk pad low; 0 releases it (open-drain).
- ps2_data_oe  out  1  1 drives the PS2Data pad low; 0 releases it.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse on device ACK.
- err  out  1  one-cycle pulse on NACK or timeout.

Function
REQ-004 SHALL pass ps2_clk_in and ps2_data_in each through a 2-flop synchronizer; a clock falling edge is valid only after the synchronized clock has been stable low for 4 consecutive clk cycles following a high level.
REQ-005 SHALL accept a byte on the cycle in which tx_valid and tx_ready are both 1, latch tx_data, compute odd parity (parity = ~^tx_data), and drop tx_ready on the next cycle.
REQ-006 SHALL implement the states IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE.
REQ-007 In IDLE, SHALL drive ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0.
REQ-008 In INHIBIT, SHALL drive ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then set ps2_data_oe=1 and go to REQUEST.
REQ-009 In REQUEST, SHALL drive ps2_clk_oe=0 and ps2_data_oe=1 (start bit = 0), and go to SHIFT on the first valid falling edge.
REQ-010 In SHIFT, the host SHALL update data after each valid falling edge n:
- n = 1..8: ps2_data_oe = ~bit[n-1], LSB first.
- n = 9: ps2_data_oe = ~parity.
- n = 10: ps2_data_oe = 0 (stop bit released high); go to ACK.
REQ-011 In ACK, SHALL sample synchronized data on the next valid falling edge: 0 means ACK, 1 means NACK. It SHALL then go to WAIT_IDLE.
REQ-012 In WAIT_IDLE, SHALL wait until synchronized clock and data are both 1, then pulse done (ACK) or err (NACK) for one cycle and return to IDLE.
REQ-013 busy SHALL be 1 in every state except IDLE; tx_ready SHALL equal (state==IDLE).
REQ-014 tx_valid asserted while busy SHALL be ignored; no queuing.
REQ-015 done and err SHALL never be asserted in the same cycle.
REQ-016 tx_data changes after acceptance SHALL NOT affect the byte in flight.

Reset
REQ-017 When rst=1 at a clk edge, SHALL go to IDLE and clear: ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, tx_ready=1 on the following cycle, and all counters and synchronizers (synchronizers to 1).
REQ-018 Reset mid-transfer SHALL release both lines immediately and SHALL NOT pulse done or err.

Configuration
REQ-019 Macro PS2_TX_TIMEOUT_EN:
- Defined: in REQUEST, SHIFT, ACK and WAIT_IDLE, a watchdog counts clk cycles since the last valid falling edge (or since state entry). On reaching TIMEOUT_CYCLES it releases both lines, pulses err one cycle and returns to IDLE.
- Undefined: no watchdog logic exists; the states wait indefinitely, and err signals NACK only.

Verification
REQ-020 Bench SHALL use INHIBIT_CYCLES=20, TIMEOUT_CYCLES=5000, and a device model clocking at 400 clk cycles per period. It SHALL cover:
- Send 0xED -> clk held low exactly 20 cycles; bits sampled 1,0,1,1,0,1,1,1, parity 1, stop 1; device ACK -> single done pulse, err=0.
- Send 0xF4 -> data bits 0,0,1,0,1,1,1,1, parity 0; device NACK (data high at edge 11) -> single err pulse, no done.
- tx_valid held high with 0xAA during a 0xED transfer -> only 0xED sent; 0xAA accepted only after tx_ready returns to 1.
- rst asserted after the 5th falling edge -> ps2_clk_oe=ps2_data_oe=0 next cycle, no done/err, tx_ready=1.
- With PS2_TX_TIMEOUT_EN defined, device never clocks -> err pulse 5000 cycles after REQUEST entry, lines released; undefined -> busy stays 1.
- A 2-cycle low glitch on ps2_clk_in during SHIFT -> no bit advance.
